// File: rtl/mem_pkg.sv
// Shared types for the OTTER memory arbiter: access size, load sign mode,
// arbiter FSM states, requester ids, and the data-side alignment check.
package mem_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } size_e;

    typedef enum logic {
        SIGNED   = 1'b0,
        UNSIGNED = 1'b1
    } sign_e;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ACCESS    = 2'b01,
        READ_WAIT = 2'b10,
        DONE      = 2'b11
    } state_e;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_D  = 1'b1
    } req_id_e;

    // Data-side alignment/size legality; the 2'b11 size code is always illegal.
    function automatic logic d_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            BYTE:    bad = 1'b0;
            HALF:    bad = off[0];
            WORD:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store-side byte steering / byte-enable generation
// and load-side lane extraction with sign or zero extension.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_we,
    output logic [31:0] st_wdata,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Replicate the store value across all lanes and enable only the addressed ones.
    always_comb begin
        st_we    = 4'b0000;
        st_wdata = 32'h0000_0000;
        case (st_size)
            BYTE: begin
                st_we    = 4'b0001 << st_off;
                st_wdata = {4{st_data[7:0]}};
            end
            HALF: begin
                st_we    = 4'b0011 << st_off;
                st_wdata = {2{st_data[15:0]}};
            end
            WORD: begin
                st_we    = 4'b1111;
                st_wdata = st_data;
            end
            default: begin
                st_we    = 4'b0000;
                st_wdata = 32'h0000_0000;
            end
        endcase
    end

    // Pick the addressed byte and halfword out of the raw RAM word.
    always_comb begin
        byte_s = 8'h00;
        case (ld_off)
            2'b00:   byte_s = ld_raw[7:0];
            2'b01:   byte_s = ld_raw[15:8];
            2'b10:   byte_s = ld_raw[23:16];
            2'b11:   byte_s = ld_raw[31:24];
            default: byte_s = ld_raw[7:0];
        endcase
        if (ld_off[1]) begin
            half_s = ld_raw[31:16];
        end else begin
            half_s = ld_raw[15:0];
        end
    end

    // Extend the selected lane; words and fetches pass straight through.
    always_comb begin
        ld_data = ld_raw;
        case (ld_size)
            BYTE: begin
                if (ld_sign == SIGNED) begin
                    ld_data = {{24{byte_s[7]}}, byte_s};
                end else begin
                    ld_data = {24'h00_0000, byte_s};
                end
            end
            HALF: begin
                if (ld_sign == SIGNED) begin
                    ld_data = {{16{half_s[15]}}, half_s};
                end else begin
                    ld_data = {16'h0000, half_s};
                end
            end
            WORD:    ld_data = ld_raw;
            default: ld_data = ld_raw;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin sequencer sharing one byte-enable block RAM between instruction
// fetch and data load/store. Illegal requests are answered without touching RAM.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int BUS_WIDTH  = 32
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [BUS_WIDTH-1:0]  if_addr,
    output logic [BUS_WIDTH-1:0]  if_rdata,
    output logic                  if_done,
    output logic                  if_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [BUS_WIDTH-1:0]  d_addr,
    input  logic [BUS_WIDTH-1:0]  d_wdata,
    input  logic [1:0]            d_size,
    input  logic                  d_sign,
    output logic [BUS_WIDTH-1:0]  d_rdata,
    output logic                  d_done,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [3:0]            ram_we,
    output logic [BUS_WIDTH-1:0]  ram_wdata,
    input  logic [BUS_WIDTH-1:0]  ram_rdata
);

    state_e               state_r;
    state_e               next_state_s;
    req_id_e              last_grant_r;
    req_id_e              owner_r;
    logic                 we_r;
    logic [1:0]           size_r;
    logic                 sign_r;
    logic [1:0]           off_r;

    logic                 grant_s;
    req_id_e              grant_id_s;
    logic [BUS_WIDTH-1:0] sel_addr_s;
    logic                 range_err_s;
    logic                 err_s;

    logic [3:0]           st_we_s;
    logic [BUS_WIDTH-1:0] st_wdata_s;
    logic [BUS_WIDTH-1:0] ld_data_s;

    // Store steering uses the live data-port operands (needed at grant time);
    // load formatting uses the operands captured at grant.
    mem_align u_align (
        .st_size  (d_size),
        .st_off   (d_addr[1:0]),
        .st_data  (d_wdata),
        .st_we    (st_we_s),
        .st_wdata (st_wdata_s),
        .ld_size  (size_r),
        .ld_sign  (sign_r),
        .ld_off   (off_r),
        .ld_raw   (ram_rdata),
        .ld_data  (ld_data_s)
    );

    // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last.
    always_comb begin
        grant_s    = 1'b0;
        grant_id_s = REQ_IF;
        if (if_req && d_req) begin
            grant_s    = 1'b1;
            grant_id_s = (last_grant_r == REQ_IF) ? REQ_D : REQ_IF;
        end else if (if_req) begin
            grant_s    = 1'b1;
            grant_id_s = REQ_IF;
        end else if (d_req) begin
            grant_s    = 1'b1;
            grant_id_s = REQ_D;
        end else begin
            grant_s    = 1'b0;
            grant_id_s = REQ_IF;
        end
    end

    // Range and alignment checks on the candidate winner's operands.
    always_comb begin
        sel_addr_s  = (grant_id_s == REQ_IF) ? if_addr : d_addr;
        range_err_s = |sel_addr_s[BUS_WIDTH-1:ADDR_WIDTH];
        if (grant_id_s == REQ_IF) begin
            err_s = range_err_s | (if_addr[1:0] != 2'b00);
        end else begin
            err_s = range_err_s | d_misaligned(d_size, d_addr[1:0]);
        end
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    next_state_s = err_s ? DONE : ACCESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            ACCESS:    next_state_s = we_r ? DONE : READ_WAIT;
            READ_WAIT: next_state_s = DONE;
            DONE:      next_state_s = IDLE;
            default:   next_state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Grant capture, RAM drive and response registers; pulses clear every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= REQ_D;
            owner_r      <= REQ_IF;
            we_r         <= 1'b0;
            size_r       <= 2'b00;
            sign_r       <= 1'b0;
            off_r        <= 2'b00;
            ram_addr     <= '0;
            ram_we       <= 4'b0000;
            ram_wdata    <= '0;
            if_done      <= 1'b0;
            if_err       <= 1'b0;
            if_rdata     <= '0;
            d_done       <= 1'b0;
            d_err        <= 1'b0;
            d_rdata      <= '0;
        end else begin
            ram_we    <= 4'b0000;
            ram_wdata <= '0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        last_grant_r <= grant_id_s;
                        owner_r      <= grant_id_s;
                        off_r        <= sel_addr_s[1:0];
                        if (grant_id_s == REQ_D) begin
                            we_r   <= d_we;
                            size_r <= d_size;
                            sign_r <= d_sign;
                        end else begin
                            we_r   <= 1'b0;
                            size_r <= WORD;
                            sign_r <= UNSIGNED;
                        end
                        if (err_s) begin
                            if (grant_id_s == REQ_IF) begin
                                if_done <= 1'b1;
                                if_err  <= 1'b1;
                            end else begin
                                d_done <= 1'b1;
                                d_err  <= 1'b1;
                            end
                        end else begin
                            ram_addr <= {sel_addr_s[ADDR_WIDTH-1:2], 2'b00};
                            if ((grant_id_s == REQ_D) && d_we) begin
                                ram_we    <= st_we_s;
                                ram_wdata <= st_wdata_s;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (we_r) begin
                        d_done <= 1'b1;
                    end
                end
                READ_WAIT: begin
                    if (owner_r == REQ_IF) begin
                        if_done  <= 1'b1;
                        if_rdata <= ld_data_s;
                    end else begin
                        d_done  <= 1'b1;
                        d_rdata <= ld_data_s;
                    end
                end
                DONE: begin
                    ram_we <= 4'b0000;
                end
                default: begin
                    ram_we <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural synchronous RAM, per-feature
// test tasks, and a queue of expected responses filled as stimulus is driven.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [1:0]  d_size = 2'b00;
    logic        d_sign = 1'b0;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic [12:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [32:0] ord_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    logic [31:0] mem [0:2047];
    logic        bd_we = 1'b0;
    logic [10:0] bd_idx = 11'd0;
    logic [31:0] bd_data = 32'h0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(13), .BUS_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_size(d_size),
        .d_sign(d_sign), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Byte-enable RAM with one-cycle read latency plus a backdoor preload port.
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we[b]) mem[ram_addr[12:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_addr[12:2]];
    end

    task automatic bd_write(input logic [10:0] idx, input logic [31:0] data);
        @(negedge clk);
        bd_idx = idx; bd_data = data; bd_we = 1'b1;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Issue one data request and wait (bounded) for d_done; lat=-1 on timeout.
    task automatic run_d(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic sign,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output logic [3:0] we_obs, output logic [31:0] wd_obs, output logic other);
        @(negedge clk);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_size = size; d_sign = sign;
        lat = -1; rdata = 32'h0; err = 1'b0; we_obs = 4'b0; wd_obs = 32'h0; other = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (ram_we != 4'b0000) begin we_obs = ram_we; wd_obs = ram_wdata; end
            if (if_done || if_err || (if_rdata != 32'h0)) other = 1'b1;
            if (d_done) begin rdata = d_rdata; err = d_err; lat = c; end
        end
        d_req = 1'b0; d_we = 1'b0;
    endtask

    // Issue one fetch and wait (bounded) for if_done; lat=-1 on timeout.
    task automatic run_if(input logic [31:0] addr, output logic [31:0] rdata, output logic err,
                          output int lat, output logic other);
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        lat = -1; rdata = 32'h0; err = 1'b0; other = 1'b0;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(negedge clk);
            if (d_done || d_err || (d_rdata != 32'h0) || (ram_we != 4'b0000)) other = 1'b1;
            if (if_done) begin rdata = if_rdata; err = if_err; lat = c; end
        end
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata} !== 49'h0) begin
            n_fail++; $display("FAIL reset_ram: got we=%b addr=%h wdata=%h required all 0", ram_we, ram_addr, ram_wdata);
        end
        n_checks++;
        if ({if_done, if_err, if_rdata, d_done, d_err, d_rdata} !== 68'h0) begin
            n_fail++; $display("FAIL reset_resp: got if=%b/%b/%h d=%b/%b/%h required all 0", if_done, if_err, if_rdata, d_done, d_err, d_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        logic [31:0] rd; logic er; int lt; logic oth; exp_t e;
        bd_write(11'd4, 32'h00C0FFEE);
        sb.push_back('{rdata: 32'h00C0FFEE, err: 1'b0, lat: 3});
        run_if(32'h10, rd, er, lt, oth);
        e = sb.pop_front();
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL fetch_data: got %h required %h", rd, e.rdata); end
        n_checks++; if (er !== e.err) begin n_fail++; $display("FAIL fetch_err: got %b required %b", er, e.err); end
        n_checks++; if (lt !== e.lat) begin n_fail++; $display("FAIL fetch_latency: got %0d required %0d", lt, e.lat); end
        n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL fetch_other_side: got %b required 0", oth); end
    endtask

    task automatic test_byte_store_load();
        logic [31:0] rd; logic er; int lt; logic [3:0] wo; logic [31:0] wdo; logic oth; exp_t e;
        logic [31:0] la [3]; logic [1:0] ls [3]; logic lg [3]; logic [31:0] lx [3];
        bd_write(11'd8, 32'h0000_0000);
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
        run_d(1'b1, 32'h23, 32'h000000AB, 2'b00, 1'b0, rd, er, lt, wo, wdo, oth);
        e = sb.pop_front();
        n_checks++; if (wo !== 4'b1000) begin n_fail++; $display("FAIL sb_ram_we: got %b required 1000", wo); end
        n_checks++; if (wdo !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_ram_wdata: got %h required ABABABAB", wdo); end
        n_checks++; if (lt !== e.lat) begin n_fail++; $display("FAIL sb_latency: got %0d required %0d", lt, e.lat); end
        n_checks++; if ({er, rd} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL sb_resp: got err=%b rdata=%h required err=%b rdata=%h", er, rd, e.err, e.rdata); end
        n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL sb_other_side: got %b required 0", oth); end
        la[0] = 32'h23; ls[0] = 2'b00; lg[0] = 1'b0; lx[0] = 32'hFFFFFFAB;
        la[1] = 32'h23; ls[1] = 2'b00; lg[1] = 1'b1; lx[1] = 32'h000000AB;
        la[2] = 32'h22; ls[2] = 2'b01; lg[2] = 1'b0; lx[2] = 32'hFFFFAB00;
        for (int i = 0; i < 3; i++) begin
            sb.push_back('{rdata: lx[i], err: 1'b0, lat: 3});
            run_d(1'b0, la[i], 32'h0, ls[i], lg[i], rd, er, lt, wo, wdo, oth);
            e = sb.pop_front();
            n_checks++; if ({er, rd} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL load_%0d: got err=%b rdata=%h required err=%b rdata=%h", i, er, rd, e.err, e.rdata); end
            n_checks++; if (lt !== e.lat) begin n_fail++; $display("FAIL load_%0d_latency: got %0d required %0d", i, lt, e.lat); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lt; logic [3:0] wo; logic [31:0] wdo; logic oth; exp_t e;
        logic [31:0] ea [4]; logic ew [4]; logic [1:0] es [4];
        ea[0] = 32'h21;   ew[0] = 1'b0; es[0] = 2'b01;
        ea[1] = 32'h22;   ew[1] = 1'b1; es[1] = 2'b10;
        ea[2] = 32'h20;   ew[2] = 1'b0; es[2] = 2'b11;
        ea[3] = 32'h2000; ew[3] = 1'b0; es[3] = 2'b10;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
            run_d(ew[i], ea[i], 32'h5555AAAA, es[i], 1'b0, rd, er, lt, wo, wdo, oth);
            e = sb.pop_front();
            n_checks++; if ({er, rd} !== {e.err, e.rdata}) begin n_fail++; $display("FAIL derr_%0d: got err=%b rdata=%h required err=%b rdata=%h", i, er, rd, e.err, e.rdata); end
            n_checks++; if (lt !== e.lat) begin n_fail++; $display("FAIL derr_%0d_latency: got %0d required %0d", i, lt, e.lat); end
            n_checks++; if (wo !== 4'b0000) begin n_fail++; $display("FAIL derr_%0d_ram_we: got %b required 0000", i, wo); end
        end
        sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
        run_if(32'h12, rd, er, lt, oth);
        e = sb.pop_front();
        n_checks++; if ({er, rd, lt} !== {e.err, e.rdata, e.lat}) begin n_fail++; $display("FAIL iferr_misalign: got err=%b rdata=%h lat=%0d required err=%b lat=%0d", er, rd, lt, e.err, e.lat); end
        n_checks++; if (oth !== 1'b0) begin n_fail++; $display("FAIL iferr_ram_activity: got %b required 0", oth); end
    endtask

    task automatic test_fairness();
        int ndone; logic prev_if; logic prev_d; logic [32:0] e; logic [32:0] got;
        bd_write(11'd9, 32'h5A5A1234);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24; d_size = 2'b10; d_sign = 1'b0;
        ord_q.push_back({1'b0, 32'h00C0FFEE});
        ord_q.push_back({1'b1, 32'h5A5A1234});
        ord_q.push_back({1'b0, 32'h00C0FFEE});
        ord_q.push_back({1'b1, 32'h5A5A1234});
        ndone = 0; prev_if = 1'b0; prev_d = 1'b0;
        for (int c = 0; c < 80 && ndone < 4; c++) begin
            @(negedge clk);
            if (if_done || d_done) begin
                e = ord_q.pop_front();
                got = {d_done, d_done ? d_rdata : if_rdata};
                n_checks++; if (got !== e) begin n_fail++; $display("FAIL fair_order_%0d: got id=%b data=%h required id=%b data=%h", ndone, got[32], got[31:0], e[32], e[31:0]); end
                n_checks++; if ((if_done && d_done) || (prev_if && if_done) || (prev_d && d_done)) begin n_fail++; $display("FAIL fair_pulse_%0d: got if=%b d=%b prev if=%b d=%b required single 1-cycle pulse", ndone, if_done, d_done, prev_if, prev_d); end
                ndone++;
                if (ndone == 4) begin if_req = 1'b0; d_req = 1'b0; end
            end
            prev_if = if_done; prev_d = d_done;
        end
        n_checks++; if (ndone !== 4) begin n_fail++; $display("FAIL fair_count: got %0d dones required 4", ndone); end
        @(negedge clk);
        n_checks++; if ({if_done, d_done} !== 2'b00) begin n_fail++; $display("FAIL fair_tail: got if=%b d=%b required 00", if_done, d_done); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lt; logic [3:0] wo; logic [31:0] wdo; logic oth; exp_t e;
        bd_write(11'd12, 32'h11111111);
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hDEADBEEF; d_size = 2'b10; d_sign = 1'b0;
        @(negedge clk);
        n_checks++; if (ram_we !== 4'b1111) begin n_fail++; $display("FAIL abort_access_we: got %b required 1111", ram_we); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if ({ram_we, d_done} !== 5'b0) begin n_fail++; $display("FAIL abort_after_reset: got we=%b d_done=%b required 0000/0", ram_we, d_done); end
        n_checks++; if (dut.state_r !== 2'b00) begin n_fail++; $display("FAIL abort_state: got %b required IDLE(00)", dut.state_r); end
        rst = 1'b0;
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
        lt = -1; er = 1'b1;
        for (int c = 1; c <= 20 && lt < 0; c++) begin
            @(negedge clk);
            if (d_done) begin lt = c; er = d_err; end
        end
        d_req = 1'b0; d_we = 1'b0;
        e = sb.pop_front();
        n_checks++; if ({lt, er} !== {e.lat, e.err}) begin n_fail++; $display("FAIL abort_reissue: got lat=%0d err=%b required lat=%0d err=%b", lt, er, e.lat, e.err); end
        sb.push_back('{rdata: 32'hDEADBEEF, err: 1'b0, lat: 3});
        run_d(1'b0, 32'h30, 32'h0, 2'b10, 1'b0, rd, er, lt, wo, wdo, oth);
        e = sb.pop_front();
        n_checks++; if (rd !== e.rdata) begin n_fail++; $display("FAIL abort_readback: got %h required %h", rd, e.rdata); end
    endtask

    task automatic test_half_store();
        logic [31:0] rd; logic er; int lt; logic [3:0] wo; logic [31:0] wdo; logic oth; exp_t e;
        bd_write(11'd0, 32'hFFFFFFFF);
        sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
        run_d(1'b1, 32'h02, 32'h00001234, 2'b01, 1'b0, rd, er, lt, wo, wdo, oth);
        e = sb.pop_front();
        n_checks++; if ({wo, wdo} !== {4'b1100, 32'h12341234}) begin n_fail++; $display("FAIL half_store_lanes: got we=%b wdata=%h required 1100/12341234", wo, wdo); end
        n_checks++; if ({lt, er, rd} !== {e.lat, e.err, e.rdata}) begin n_fail++; $display("FAIL half_store_resp: got lat=%0d err=%b rdata=%h required lat=%0d err=%b rdata=%h", lt, er, rd, e.lat, e.err, e.rdata); end
        sb.push_back('{rdata: 32'h1234FFFF, err: 1'b0, lat: 3});
        run_d(1'b0, 32'h00, 32'h0, 2'b10, 1'b0, rd, er, lt, wo, wdo, oth);
        e = sb.pop_front();
        n_checks++; if ({rd, er} !== {e.rdata, e.err}) begin n_fail++; $display("FAIL half_merge_load: got %h err=%b required %h", rd, er, e.rdata); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_byte_store_load();
        test_errors();
        test_fairness();
        test_reset_abort();
        test_half_store();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-port byte-enable block RAM in the OTTER multicycle CPU and shares it between two requesters: instruction fetch (IF) and data load/store (D).
- Round-robin arbitration between IF and D.
- Store: byte-lane steering and byte-enable generation.
- Load: lane extraction plus sign/zero extension.
- Alignment and range error detection, done before any RAM access.

Parameters:
ADDR_WIDTH, 13, number of byte-address bits backed by RAM
BUS_WIDTH, 32, data bus width; only 32 is supported

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
if_req  in  1  fetch request; held high until if_done
if_addr  in  BUS_WIDTH  fetch byte address
if_rdata  out  BUS_WIDTH  fetched word, valid while if_done=1
if_done  out  1  one-cycle completion pulse
if_err  out  1  fetch error, valid while if_done=1
d_req  in  1  data request; held high until d_done
d_we  in  1  1=store, 0=load
d_addr  in  BUS_WIDTH  data byte address
d_wdata  in  BUS_WIDTH  store data, right-justified
d_size  in  2  00=BYTE, 01=HALF, 10=WORD, 11=illegal
d_sign  in  1  0=SIGNED, 1=UNSIGNED (loads only)
d_rdata  out  BUS_WIDTH  formatted load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse
d_err  out  1  data error, valid while d_done=1
ram_addr  out  ADDR_WIDTH  word-aligned RAM address {addr[ADDR_WIDTH-1:2],2'b00}
ram_we  out  4  RAM byte write enables
ram_wdata  out  BUS_WIDTH  lane-steered store data
ram_rdata  in  BUS_WIDTH  RAM read data, 1-cycle synchronous latency

Behaviour:
- Reset (synchronous): state=IDLE, last_grant=D, and the following outputs/registers are 0: ram_we, ram_addr, ram_wdata, every *_done, *_err, *_rdata. Reset mid-operation aborts the access; ram_we is 0 from the next edge; no done pulse is produced for the aborted request.
- FSM states: IDLE, ACCESS, READ_WAIT, DONE.
- IDLE:
  - Only one req high: grant that requester.
  - Both high: grant the one not equal to last_grant.
  - On grant: register addr, we, size, sign, wdata and the requester id; update last_grant.
  - Error checks at grant. Error -> DONE with err=1 and no RAM access. Otherwise -> ACCESS.
- Error conditions:
  - Any addr bit [BUS_WIDTH-1:ADDR_WIDTH] nonzero.
  - IF: if_addr[1:0]!=0.
  - D: size=11; HALF with addr[0]=1; WORD with addr[1:0]!=0.
- ACCESS:
  - Drive ram_addr.
  - Store: drive ram_we/ram_wdata for exactly this cycle, then -> DONE.
  - Load or fetch: ram_we=0, then -> READ_WAIT.
- READ_WAIT: capture ram_rdata, format it into the response register, then -> DONE.
- DONE: assert the granted requester's done for one cycle, with rdata/err from the response register; -> IDLE.
- Latency, request accepted at edge 0: error done in cycle 1; store done in cycle 2; load/fetch done in cycle 3. Throughput is 1 access per 3–4 cycles.
- Requesters hold req and operands stable until they sample done, then drop req on that edge. A req still high in IDLE after its done is treated as a new request.
- Store steering (o=addr[1:0]):
  - BYTE: we=0001<<o; wdata={4{wdata[7:0]}}.
  - HALF: we=0011<<o; wdata={2{wdata[15:0]}}.
  - WORD: we=1111; wdata unchanged.
- Load formatting:
  - BYTE: byte = rdata[8*o+7:8*o].
  - HALF: half = rdata[16*o[1]+15:16*o[1]].
  - Extension: sign-extend when d_sign=0, zero-extend when d_sign=1.
  - WORD and fetch: rdata passed through unchanged.
- A store never returns data: d_rdata=0 on store done.
- Outputs for the non-granted requester stay 0.
- Requests arriving during a busy state are ignored until IDLE.
- Fairness: with both requesters continuously asserting, grants alternate IF, D, IF, ...

Decomposition:
- Package mem_pkg:
  - Size enum: BYTE=2'b00, HALF=2'b01, WORD=2'b10.
  - Sign enum: SIGNED=1'b0, UNSIGNED=1'b1.
  - FSM state enum.
  - Requester id enum: REQ_IF, REQ_D.
- Sub-module mem_align: purely combinational; store lane steering/we generation and load extraction/extension. Instantiated once.
- mem_arbiter holds the FSM, arbitration, error checks and registers.

Test Plan:
- After reset, if_req=1, if_addr=0x10, RAM word[4]=0x00C0FFEE -> if_done in cycle 3, if_rdata=0x00C0FFEE, if_err=0.
- D store BYTE, d_addr=0x23, d_wdata=0x000000AB -> ram_we=1000 and ram_wdata=0xABABABAB in ACCESS; d_done in cycle 2. A following signed BYTE load from 0x23 returns 0xFFFFFFAB; an unsigned one returns 0x000000AB.
- HALF load at 0x21, WORD store at 0x22, size=11, and addr=0x00002000 (ADDR_WIDTH=13) -> each gives done in cycle 1 with err=1, and ram_we stays 0000 throughout.
- if_req and d_req both held high continuously for 4 transactions -> grant order IF, D, IF, D (last_grant reset to D); each done pulses exactly 1 cycle.
- Store WORD in flight, rst asserted during ACCESS -> ram_we=0 next cycle, no d_done, state IDLE; the re-issued request completes normally.
- HALF store 0x1234 at 0x02 over 0xFFFFFFFF, then WORD load -> 0x1234FFFF.
